// File: rtl/vram_arbiter.sv
// Single-port SRAM frame-buffer arbiter: fixed-latency video reads pre-empt FIFO-queued capture writes.
// Optional write-stall counter is built when VRAM_ARB_STATS_EN is defined.
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rd_req,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_rd_valid,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W-1:0]             i_wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [ADDR_W-1:0]             o_sram_addr,
    output logic [DATA_W-1:0]             o_sram_wdata,
    output logic                          o_sram_wdata_oe,
    output logic                          o_sram_we_n,
    output logic                          o_sram_oe_n,
`ifdef VRAM_ARB_STATS_EN
    input  logic                          i_stats_clr,
    output logic [15:0]                   o_stall_cnt,
`endif
    input  logic [DATA_W-1:0]             i_sram_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_TURN,
        ST_WRITE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    state_t            state;
    state_t            state_nxt;
    wr_entry_t         fifo_mem [FIFO_DEPTH];
    wr_entry_t         head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              rd_pipe;

    logic [ADDR_W-1:0] sram_addr_nxt;
    logic [DATA_W-1:0] sram_wdata_nxt;
    logic              we_n_nxt;
    logic              oe_n_nxt;
    logic              wdata_oe_nxt;

    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (o_fifo_level == '0);
    assign push       = i_wr_valid & o_wr_ready;
    assign level_nxt  = o_fifo_level + LVL_W'(push) - LVL_W'(pop);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next SRAM pin values; reads always win, a read->write switch costs one dead cycle
    always_comb begin
        state_nxt      = ST_IDLE;
        sram_addr_nxt  = o_sram_addr;
        sram_wdata_nxt = o_sram_wdata;
        we_n_nxt       = 1'b1;
        oe_n_nxt       = 1'b1;
        wdata_oe_nxt   = 1'b0;
        pop            = 1'b0;
        if (i_rd_req) begin
            state_nxt     = ST_READ;
            sram_addr_nxt = i_rd_addr;
            oe_n_nxt      = 1'b0;
        end else if (!fifo_empty) begin
            if (state == ST_READ) begin
                state_nxt = ST_TURN;
            end else begin
                state_nxt      = ST_WRITE;
                sram_addr_nxt  = head.addr;
                sram_wdata_nxt = head.data;
                we_n_nxt       = 1'b0;
                wdata_oe_nxt   = 1'b1;
                pop            = 1'b1;
            end
        end
    end

    // Registered SRAM pins; reset releases the bus immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sram_addr     <= '0;
            o_sram_wdata    <= '0;
            o_sram_wdata_oe <= 1'b0;
            o_sram_we_n     <= 1'b1;
            o_sram_oe_n     <= 1'b1;
        end else begin
            o_sram_addr     <= sram_addr_nxt;
            o_sram_wdata    <= sram_wdata_nxt;
            o_sram_wdata_oe <= wdata_oe_nxt;
            o_sram_we_n     <= we_n_nxt;
            o_sram_oe_n     <= oe_n_nxt;
        end
    end

    // Write FIFO storage; contents are don't-care while empty, so no reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_entry_t'{addr: i_wr_addr, data: i_wr_data};
        end
    end

    // FIFO pointers, level and registered ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_level <= '0;
            o_wr_ready   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_fifo_level <= level_nxt;
            o_wr_ready   <= (level_nxt < LVL_W'(FIFO_DEPTH));
        end
    end

    // Two-cycle read pipeline: data captured at the edge that ends the READ cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pipe    <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            rd_pipe    <= i_rd_req;
            o_rd_valid <= rd_pipe;
            if (state == ST_READ) begin
                o_rd_data <= i_sram_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STATS_EN
    // Saturating count of cycles where capture was back-pressured
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (i_stats_clr) begin
            o_stall_cnt <= '0;
        end else if (i_wr_valid && !o_wr_ready && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_vram_arbiter;

    localparam int unsigned AW    = 18;
    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 4;

    localparam int K_IDLE  = 0;
    localparam int K_READ  = 1;
    localparam int K_TURN  = 2;
    localparam int K_WRITE = 3;

    logic          clk;
    logic          rst_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [LW-1:0] fifo_level;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_wdata_oe;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic [DW-1:0] sram_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   stall_cnt;
`endif

    int tests;
    int failed;

    vram_arbiter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rd_req        (rd_req),
        .i_rd_addr       (rd_addr),
        .o_rd_data       (rd_data),
        .o_rd_valid      (rd_valid),
        .i_wr_valid      (wr_valid),
        .o_wr_ready      (wr_ready),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data),
        .o_fifo_level    (fifo_level),
        .o_sram_addr     (sram_addr),
        .o_sram_wdata    (sram_wdata),
        .o_sram_wdata_oe (sram_wdata_oe),
        .o_sram_we_n     (sram_we_n),
        .o_sram_oe_n     (sram_oe_n),
`ifdef VRAM_ARB_STATS_EN
        .i_stats_clr     (stats_clr),
        .o_stall_cnt     (stall_cnt),
`endif
        .i_sram_rdata    (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: unwritten words read back as addr[11:0]
    logic [DW-1:0] sram [0:(1<<AW)-1];
    bit            sram_wr [0:(1<<AW)-1];
    assign sram_rdata = sram_oe_n ? '0 : (sram_wr[sram_addr] ? sram[sram_addr] : DW'(sram_addr));
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram[sram_addr]    <= sram_wdata;
            sram_wr[sram_addr] <= 1'b1;
        end
    end

    // Reference model state
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t            q[$];
    logic [DW-1:0]  mem [int];
    int             cur_kind;
    bit             pend;
    wr_t            pend_w;
    logic [AW-1:0]  e_addr;
    logic [DW-1:0]  e_wdata;
    logic           e_oe, e_we_n, e_oe_n, e_valid, e_s1, e_ready;
    logic [DW-1:0]  e_rdata;
    logic [LW-1:0]  e_level;
    int             e_stall;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return DW'(a);
    endfunction

    task automatic model_reset();
        q.delete();
        cur_kind = K_IDLE;
        pend     = 1'b0;
        e_addr   = '0;
        e_wdata  = '0;
        e_oe     = 1'b0;
        e_we_n   = 1'b1;
        e_oe_n   = 1'b1;
        e_valid  = 1'b0;
        e_s1     = 1'b0;
        e_ready  = 1'b0;
        e_rdata  = '0;
        e_level  = '0;
        e_stall  = 0;
    endtask

    // Predict the visible state after the coming rising edge from the inputs now applied
    task automatic model_step();
        int  kind;
        bit  push;
        wr_t h;
        wr_t n;
        if (pend) begin
            mem[int'(pend_w.a)] = pend_w.d;
            pend = 1'b0;
        end
        if (cur_kind == K_READ) e_rdata = mem_rd(e_addr);
        e_valid = e_s1;
        e_s1    = rd_req;
        push    = wr_valid && e_ready;
`ifdef VRAM_ARB_STATS_EN
        if (stats_clr) e_stall = 0;
        else if (wr_valid && !e_ready && e_stall < 65535) e_stall++;
`endif
        if (rd_req) kind = K_READ;
        else if (q.size() != 0) kind = (cur_kind == K_READ) ? K_TURN : K_WRITE;
        else kind = K_IDLE;
        e_oe_n = 1'b1;
        e_we_n = 1'b1;
        e_oe   = 1'b0;
        if (kind == K_READ) begin
            e_addr = rd_addr;
            e_oe_n = 1'b0;
        end else if (kind == K_WRITE) begin
            h       = q.pop_front();
            e_addr  = h.a;
            e_wdata = h.d;
            e_we_n  = 1'b0;
            e_oe    = 1'b1;
            pend    = 1'b1;
            pend_w  = h;
        end
        if (push) begin
            n.a = wr_addr;
            n.d = wr_data;
            q.push_back(n);
        end
        e_level  = LW'(q.size());
        e_ready  = (q.size() < DEPTH);
        cur_kind = kind;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sram_addr",  32'(sram_addr),     32'(e_addr));
        chk("sram_wdata", 32'(sram_wdata),    32'(e_wdata));
        chk("wdata_oe",   32'(sram_wdata_oe), 32'(e_oe));
        chk("we_n",       32'(sram_we_n),     32'(e_we_n));
        chk("oe_n",       32'(sram_oe_n),     32'(e_oe_n));
        chk("rd_valid",   32'(rd_valid),      32'(e_valid));
        chk("rd_data",    32'(rd_data),       32'(e_rdata));
        chk("wr_ready",   32'(wr_ready),      32'(e_ready));
        chk("fifo_level", 32'(fifo_level),    32'(e_level));
`ifdef VRAM_ARB_STATS_EN
        chk("stall_cnt",  32'(stall_cnt),     32'(e_stall));
`endif
    endtask

    // Apply inputs for one cycle, advance the model, sample at the next falling edge
    task automatic step(input logic r, input logic [AW-1:0] ra,
                        input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        rd_req   = r;
        rd_addr  = ra;
        wr_valid = w;
        wr_addr  = wa;
        wr_data  = wd;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return {9'($urandom_range(0, 3)), 9'($urandom_range(0, 7))};
    endfunction

    initial begin
        int rd_pct;
        int wr_pct;
        tests    = 0;
        failed   = 0;
        rst_n    = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
`ifdef VRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        model_reset();

        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, '0, '0);
        chk("ready_after_release", 32'(wr_ready), 32'd1);

        // Back-to-back reads: data at c+2, one word per cycle, no write strobe
        for (int i = 0; i < 6; i++) begin
            step(i < 4, AW'(32'h10 + i), 1'b0, '0, '0);
            chk("rd_we_n", 32'(sram_we_n), 32'd1);
            if (i >= 1 && i <= 4) begin
                chk("rd_seq_valid", 32'(rd_valid), 32'd1);
                chk("rd_seq_data",  32'(rd_data),  32'(12'h010 + 12'(i - 1)));
            end
        end

        // Fill the FIFO under continuous reads, then drain in push order after one dead cycle
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rnd_addr(), 1'b1, AW'(32'h100 + i), DW'(32'h300 + i));
        end
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ready", 32'(wr_ready),   32'd0);
        step(1'b0, '0, 1'b0, '0, '0);
        chk("turn_we_n", 32'(sram_we_n), 32'd1);
        chk("turn_oe_n", 32'(sram_oe_n), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b0, '0, '0);
            chk("drain_we_n", 32'(sram_we_n), 32'd0);
            chk("drain_addr", 32'(sram_addr), 32'h100 + 32'(i));
        end
        step(1'b0, '0, 1'b0, '0, '0);
        chk("drain_ready", 32'(wr_ready), 32'd1);

        // Pre-emption of a 3-entry burst after its first write
        for (int i = 0; i < 3; i++) begin
            step(1'b1, AW'(32'h100 + i), 1'b1, AW'(32'h100 + i), DW'(32'h5A0 + i));
        end
        step(1'b0, '0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, '0, '0);
        step(1'b1, AW'(32'h101), 1'b0, '0, '0);
        chk("preempt_oe_n",  32'(sram_oe_n),  32'd0);
        chk("preempt_level", 32'(fifo_level), 32'd2);
        repeat (5) step(1'b0, '0, 1'b0, '0, '0);

        // Random traffic in phases of varying read pressure
        for (int c = 0; c < 800; c++) begin
            case ((c / 100) % 4)
                0: begin rd_pct = 50; wr_pct = 50; end
                1: begin rd_pct = 95; wr_pct = 80; end
                2: begin rd_pct = 0;  wr_pct = 40; end
                default: begin rd_pct = 30; wr_pct = 90; end
            endcase
`ifdef VRAM_ARB_STATS_EN
            stats_clr = ($urandom_range(0, 99) < 2);
`endif
            step($urandom_range(0, 99) < rd_pct, rnd_addr(),
                 $urandom_range(0, 99) < wr_pct, rnd_addr(), DW'($urandom));
        end
`ifdef VRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        // Async reset in the middle of a WRITE cycle
        repeat (12) step(1'b0, '0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, AW'(32'h20001), DW'(32'hABC));
        step(1'b0, '0, 1'b0, '0, '0);
        chk("idle_wr_we_n",  32'(sram_we_n),     32'd0);
        chk("idle_wr_oe",    32'(sram_wdata_oe), 32'd1);
        chk("idle_wr_addr",  32'(sram_addr),     32'h20001);
        chk("idle_wr_data",  32'(sram_wdata),    32'hABC);
        chk("idle_wr_level", 32'(fifo_level),    32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we_n",  32'(sram_we_n),     32'd1);
        chk("rst_oe",    32'(sram_wdata_oe), 32'd0);
        chk("rst_oe_n",  32'(sram_oe_n),     32'd1);
        chk("rst_ready", 32'(wr_ready),      32'd0);
        @(negedge clk);
        model_reset();
        check_all();
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, '0, '0);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("post_rst_valid", 32'(rd_valid),   32'd0);

        for (int c = 0; c < 150; c++) begin
            step($urandom_range(0, 99) < 40, rnd_addr(),
                 $urandom_range(0, 99) < 60, rnd_addr(), DW'($urandom));
        end
        repeat (12) step(1'b0, '0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
